// File: rtl/sme_stream_arbiter.sv
// Round-robin packet arbiter in front of the SME: grants whole packets (meta then data)
// and routes SME match results back to the packet owners in grant order.
module sme_stream_arbiter #(
  parameter int PORTS      = 4,
  parameter int BYTE_COUNT = 16,
  parameter int STRB_COUNT = $clog2(BYTE_COUNT),
  parameter int TAG_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic [PORTS*BYTE_COUNT*8-1:0]    s_axis_tdata,
  input  logic [PORTS*STRB_COUNT-1:0]      s_axis_tempty,
  input  logic [PORTS-1:0]                 s_axis_tvalid,
  input  logic [PORTS-1:0]                 s_axis_tfirst,
  input  logic [PORTS-1:0]                 s_axis_tlast,
  output logic [PORTS-1:0]                 s_axis_tready,

  input  logic [PORTS*64-1:0]              s_meta_preamble,
  input  logic [PORTS*16-1:0]              s_meta_src_port,
  input  logic [PORTS*16-1:0]              s_meta_dst_port,
  input  logic [PORTS-1:0]                 s_meta_valid,
  output logic [PORTS-1:0]                 s_meta_ready,

  output logic [BYTE_COUNT*8-1:0]          m_axis_tdata,
  output logic [STRB_COUNT-1:0]            m_axis_tempty,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tfirst,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [63:0]                      m_meta_preamble,
  output logic [15:0]                      m_meta_src_port,
  output logic [15:0]                      m_meta_dst_port,
  output logic                             m_meta_valid,
  input  logic                             m_meta_ready,

  input  logic [31:0]                      match_rules_ID,
  input  logic                             match_last,
  input  logic                             match_valid,
  output logic                             match_release,
  input  logic [63:0]                      preamble_state_in,
  input  logic                             state_valid_in,

  output logic [31:0]                      out_rules_ID,
  output logic                             out_match_last,
  output logic [PORTS-1:0]                 out_match_valid,
  input  logic [PORTS-1:0]                 out_match_release,
  output logic [63:0]                      out_state,
  output logic [PORTS-1:0]                 out_state_valid,
  output logic                             tag_err
);

  localparam int DW = BYTE_COUNT * 8;
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t          state_reg;
  logic [IW-1:0]   grant_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [IW-1:0]   last_owner_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            tag_err_reg;
  logic [IW-1:0]   owner_mem [TAG_DEPTH];

  logic [PORTS-1:0] eligible;
  logic             any_eligible;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    rr_next;
  int               cand;
  logic             grant;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [IW-1:0]    head;
  logic             meta_hs;
  logic             beat_hs;
  logic             last_hs;

  // Only the start of a packet with its metadata present may win arbitration.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_elig
    assign eligible[gi] = s_axis_tvalid[gi] & s_axis_tfirst[gi] & s_meta_valid[gi];
  end

  always_comb begin
    any_eligible = 1'b0;
    pick_idx     = '0;
    cand         = 0;
    for (int i = 0; i < PORTS; i++) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!any_eligible && eligible[IW'(cand)]) begin
        any_eligible = 1'b1;
        pick_idx     = IW'(cand);
      end
    end
  end

  assign rr_next    = (pick_idx == IW'(PORTS - 1)) ? '0 : pick_idx + 1'b1;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(TAG_DEPTH));
  assign grant      = (state_reg == IDLE) && any_eligible && !fifo_full;
  assign push       = grant;
  assign head       = owner_mem[rd_ptr_reg];

  assign meta_hs = (state_reg == META) && m_meta_ready;
  assign beat_hs = (state_reg == DATA) && m_axis_tready && s_axis_tvalid[grant_reg];
  assign last_hs = beat_hs && s_axis_tlast[grant_reg];

  assign m_axis_tdata    = s_axis_tdata[int'(grant_reg)*DW +: DW];
  assign m_axis_tempty   = s_axis_tempty[int'(grant_reg)*STRB_COUNT +: STRB_COUNT];
  assign m_axis_tfirst   = s_axis_tfirst[grant_reg];
  assign m_axis_tlast    = s_axis_tlast[grant_reg];
  assign m_axis_tvalid   = (state_reg == DATA) && s_axis_tvalid[grant_reg];
  assign m_meta_preamble = s_meta_preamble[int'(grant_reg)*64 +: 64];
  assign m_meta_src_port = s_meta_src_port[int'(grant_reg)*16 +: 16];
  assign m_meta_dst_port = s_meta_dst_port[int'(grant_reg)*16 +: 16];
  assign m_meta_valid    = (state_reg == META);

  // With no owner queued the match stream is drained so the SME never stalls.
  assign match_release  = rst_n && (fifo_empty ? 1'b1 : out_match_release[head]);
  assign pop            = match_valid && match_release && match_last && !fifo_empty;
  assign out_rules_ID   = match_rules_ID;
  assign out_match_last = match_last;
  assign out_state      = preamble_state_in;
  assign tag_err        = tag_err_reg;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_route
    assign s_axis_tready[gi]   = (state_reg == DATA) && (grant_reg == IW'(gi)) && m_axis_tready;
    assign s_meta_ready[gi]    = (state_reg == META) && (grant_reg == IW'(gi)) && m_meta_ready;
    assign out_match_valid[gi] = rst_n && match_valid && !fifo_empty && (head == IW'(gi));
    assign out_state_valid[gi] = rst_n && state_valid_in && (last_owner_reg == IW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      last_owner_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      tag_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            state_reg  <= META;
            grant_reg  <= pick_idx;
            rr_ptr_reg <= rr_next;
          end
        end
        META: begin
          if (meta_hs) state_reg <= DATA;
        end
        DATA: begin
          if (last_hs) begin
            state_reg      <= IDLE;
            last_owner_reg <= grant_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (match_valid && fifo_empty) tag_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) owner_mem[wr_ptr_reg] <= pick_idx;
  end

endmodule

// File: tb/tb_sme_stream_arbiter.sv
// Directed bench for sme_stream_arbiter: arbitration order, latency, owner FIFO and reset.
module tb_sme_stream_arbiter;
  localparam int PORTS = 4;
  localparam int BYTE_COUNT = 16;
  localparam int STRB_COUNT = 4;
  localparam int TAG_DEPTH = 8;
  localparam int DW = BYTE_COUNT * 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]                 pdata [PORTS];
  logic [PORTS*DW-1:0]           s_axis_tdata;
  logic [PORTS*STRB_COUNT-1:0]   s_axis_tempty;
  logic [PORTS-1:0]              s_axis_tvalid, s_axis_tfirst, s_axis_tlast, s_axis_tready;
  logic [PORTS*64-1:0]           s_meta_preamble;
  logic [PORTS*16-1:0]           s_meta_src_port, s_meta_dst_port;
  logic [PORTS-1:0]              s_meta_valid, s_meta_ready;
  logic [DW-1:0]                 m_axis_tdata;
  logic [STRB_COUNT-1:0]         m_axis_tempty;
  logic                          m_axis_tvalid, m_axis_tfirst, m_axis_tlast, m_axis_tready;
  logic [63:0]                   m_meta_preamble;
  logic [15:0]                   m_meta_src_port, m_meta_dst_port;
  logic                          m_meta_valid, m_meta_ready;
  logic [31:0]                   match_rules_ID;
  logic                          match_last, match_valid, match_release;
  logic [63:0]                   preamble_state_in;
  logic                          state_valid_in;
  logic [31:0]                   out_rules_ID;
  logic                          out_match_last;
  logic [PORTS-1:0]              out_match_valid, out_match_release, out_state_valid;
  logic [63:0]                   out_state;
  logic                          tag_err;

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_pack
    assign s_axis_tdata[gi*DW +: DW]                    = pdata[gi];
    assign s_axis_tempty[gi*STRB_COUNT +: STRB_COUNT]   = 4'(gi + 8);
    assign s_meta_preamble[gi*64 +: 64]                 = 64'hCAFE_0000_0000_0000 + 64'(gi);
    assign s_meta_src_port[gi*16 +: 16]                 = 16'h0100 + 16'(gi);
    assign s_meta_dst_port[gi*16 +: 16]                 = 16'h0200 + 16'(gi);
  end

  sme_stream_arbiter #(
    .PORTS(PORTS), .BYTE_COUNT(BYTE_COUNT), .STRB_COUNT(STRB_COUNT), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tempty(s_axis_tempty), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tfirst(s_axis_tfirst), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .s_meta_preamble(s_meta_preamble), .s_meta_src_port(s_meta_src_port),
    .s_meta_dst_port(s_meta_dst_port), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tempty(m_axis_tempty), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tfirst(m_axis_tfirst), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_meta_preamble(m_meta_preamble), .m_meta_src_port(m_meta_src_port),
    .m_meta_dst_port(m_meta_dst_port), .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready),
    .match_rules_ID(match_rules_ID), .match_last(match_last), .match_valid(match_valid),
    .match_release(match_release), .preamble_state_in(preamble_state_in),
    .state_valid_in(state_valid_in), .out_rules_ID(out_rules_ID), .out_match_last(out_match_last),
    .out_match_valid(out_match_valid), .out_match_release(out_match_release),
    .out_state(out_state), .out_state_valid(out_state_valid), .tag_err(tag_err)
  );

  function automatic logic [DW-1:0] beat_data(input int p, input int b);
    logic [7:0] v;
    v = 8'(p * 16 + b);
    return {BYTE_COUNT{v}};
  endfunction

  function automatic int onehot_idx(input logic [PORTS-1:0] v);
    int r;
    r = -1;
    for (int i = PORTS - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_port(input int p, input logic v, input logic f, input logic l,
                            input logic mv, input int b);
    s_axis_tvalid[p] = v;
    s_axis_tfirst[p] = f;
    s_axis_tlast[p]  = l;
    s_meta_valid[p]  = mv;
    pdata[p]         = beat_data(p, b);
  endtask

  task automatic clear_ports();
    for (int p = 0; p < PORTS; p++) drive_port(p, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ports();
    m_axis_tready = 1'b1; m_meta_ready = 1'b1;
    match_valid = 1'b0; match_last = 1'b0; match_rules_ID = '0;
    out_match_release = '0; state_valid_in = 1'b0; preamble_state_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL reset_meta_valid: got %b want 0", m_meta_valid); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
    checks++; if (s_meta_ready !== 4'b0000) begin errors++; $display("FAIL reset_meta_ready: got %b want 0000", s_meta_ready); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive_port(0, 1, 1, 1, 1, 0);
    drive_port(2, 1, 1, 1, 1, 0);
    #1;
    checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL prio_cycle0_meta: got %b want 0", m_meta_valid); end
    @(negedge clk); #1;
    checks++; if (m_meta_valid !== 1'b1) begin errors++; $display("FAIL prio_cycle1_meta: got %b want 1", m_meta_valid); end
    checks++; if (m_meta_src_port !== 16'h0100) begin errors++; $display("FAIL prio_src_port: got %h want 0100", m_meta_src_port); end
    checks++; if (m_meta_preamble !== 64'hCAFE_0000_0000_0000) begin errors++; $display("FAIL prio_preamble: got %h want cafe000000000000", m_meta_preamble); end
    checks++; if (s_meta_ready !== 4'b0001) begin errors++; $display("FAIL prio_meta_ready: got %b want 0001", s_meta_ready); end
    @(negedge clk);
    s_meta_valid[0] = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL prio_cycle2_tvalid: got %b want 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== beat_data(0, 0)) begin errors++; $display("FAIL prio_tdata: got %h want %h", m_axis_tdata, beat_data(0, 0)); end
    checks++; if (s_axis_tready !== 4'b0001) begin errors++; $display("FAIL prio_tready: got %b want 0001", s_axis_tready); end
    checks++; if (m_axis_tempty !== 4'd8) begin errors++; $display("FAIL prio_tempty: got %0d want 8", m_axis_tempty); end
    @(negedge clk);
    drive_port(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if ({m_axis_tvalid, m_meta_valid} !== 2'b00) begin errors++; $display("FAIL prio_idle_gap: got %b want 00", {m_axis_tvalid, m_meta_valid}); end
    @(negedge clk); #1;
    checks++; if (m_meta_src_port !== 16'h0102) begin errors++; $display("FAIL prio_second_src: got %h want 0102", m_meta_src_port); end
    checks++; if (s_meta_ready !== 4'b0100) begin errors++; $display("FAIL prio_second_ready: got %b want 0100", s_meta_ready); end
    @(negedge clk);
    s_meta_valid[2] = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 4'b0100) begin errors++; $display("FAIL prio_second_tready: got %b want 0100", s_axis_tready); end
    checks++; if (m_axis_tdata !== beat_data(2, 0)) begin errors++; $display("FAIL prio_second_tdata: got %h want %h", m_axis_tdata, beat_data(2, 0)); end
    @(negedge clk);
    drive_port(2, 0, 0, 0, 0, 0);
    $display("test_priority done");
  endtask

  task automatic test_match_routing();
    match_valid = 1'b1; match_last = 1'b0; match_rules_ID = 32'hDEAD_0001;
    out_match_release = 4'b0001;
    #1;
    checks++; if (out_match_valid !== 4'b0001) begin errors++; $display("FAIL route_head0: got %b want 0001", out_match_valid); end
    checks++; if (match_release !== 1'b1) begin errors++; $display("FAIL route_release0: got %b want 1", match_release); end
    checks++; if (out_rules_ID !== 32'hDEAD_0001) begin errors++; $display("FAIL route_rules: got %h want dead0001", out_rules_ID); end
    @(negedge clk);
    match_last = 1'b1;
    #1;
    checks++; if (out_match_last !== 1'b1) begin errors++; $display("FAIL route_last: got %b want 1", out_match_last); end
    @(negedge clk);
    match_last = 1'b0;
    #1;
    checks++; if (out_match_valid !== 4'b0100) begin errors++; $display("FAIL route_head2: got %b want 0100", out_match_valid); end
    checks++; if (match_release !== 1'b0) begin errors++; $display("FAIL route_hold2: got %b want 0", match_release); end
    @(negedge clk);
    out_match_release = 4'b0100; match_last = 1'b1;
    #1;
    checks++; if (match_release !== 1'b1) begin errors++; $display("FAIL route_release2: got %b want 1", match_release); end
    @(negedge clk);
    match_valid = 1'b0; match_last = 1'b0;
    state_valid_in = 1'b1; preamble_state_in = 64'h1234_5678_9ABC_DEF0;
    #1;
    checks++; if (out_state_valid !== 4'b0100) begin errors++; $display("FAIL state_owner: got %b want 0100", out_state_valid); end
    checks++; if (out_state !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL state_data: got %h want 123456789abcdef0", out_state); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL route_no_tag_err: got %b want 0", tag_err); end
    state_valid_in = 1'b0;
    $display("test_match_routing done");
  endtask

  task automatic test_round_robin();
    int beat [PORTS];
    bit mdone [PORTS];
    int npkt, nmeta, ndata, last_cyc, g;
    int exp_order [4] = '{0, 1, 2, 3};
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int p = 0; p < PORTS; p++) begin beat[p] = 0; mdone[p] = 1'b0; end
    npkt = 0; nmeta = 0; ndata = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 80 && npkt < 8; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < PORTS; p++)
        drive_port(p, 1'b1, beat[p] == 0, beat[p] == 2, !mdone[p], beat[p]);
      #1;
      if (m_meta_valid && m_meta_ready) begin
        g = onehot_idx(s_meta_ready);
        checks++; if (g != exp_order[nmeta % 4]) begin errors++; $display("FAIL rr_grant_order: pkt %0d got port %0d want %0d", nmeta, g, exp_order[nmeta % 4]); end
        checks++; if (m_meta_src_port !== 16'h0100 + 16'(exp_order[nmeta % 4])) begin errors++; $display("FAIL rr_meta_src: got %h want %h", m_meta_src_port, 16'h0100 + 16'(exp_order[nmeta % 4])); end
        if (g >= 0) mdone[g] = 1'b1;
        nmeta++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        g = onehot_idx(s_axis_tready);
        if (g >= 0) begin
          checks++; if (m_axis_tdata !== beat_data(g, beat[g])) begin errors++; $display("FAIL rr_tdata: port %0d beat %0d got %h want %h", g, beat[g], m_axis_tdata, beat_data(g, beat[g])); end
          if (beat[g] == 2) begin beat[g] = 0; mdone[g] = 1'b0; npkt++; last_cyc = cyc; end
          else beat[g]++;
        end
        ndata++;
      end
    end
    checks++; if (npkt != 8) begin errors++; $display("FAIL rr_timeout: got %0d packets want 8", npkt); end
    checks++; if (nmeta != 8) begin errors++; $display("FAIL rr_meta_count: got %0d want 8", nmeta); end
    checks++; if (ndata != 24) begin errors++; $display("FAIL rr_data_count: got %0d want 24", ndata); end
    checks++; if (last_cyc != 39) begin errors++; $display("FAIL rr_cycle_count: last beat cycle %0d want 39", last_cyc); end
    $display("test_round_robin done: %0d packets", npkt);
  endtask

  task automatic test_fifo_full();
    @(negedge clk);
    clear_ports();
    drive_port(0, 1, 1, 1, 1, 0);
    repeat (4) begin
      #1;
      checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL full_blocks_grant: got %b want 0", m_meta_valid); end
      @(negedge clk);
    end
    match_valid = 1'b1; match_last = 1'b1; out_match_release = 4'b1111;
    #1;
    checks++; if (out_match_valid !== 4'b0001) begin errors++; $display("FAIL full_pop_head: got %b want 0001", out_match_valid); end
    @(negedge clk);
    match_valid = 1'b0; match_last = 1'b0;
    #1;
    checks++; if (m_meta_valid !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_grant: got %b want 0", m_meta_valid); end
    @(negedge clk); #1;
    checks++; if (m_meta_valid !== 1'b1) begin errors++; $display("FAIL full_regrant: got %b want 1", m_meta_valid); end
    checks++; if (s_meta_ready !== 4'b0001) begin errors++; $display("FAIL full_regrant_port: got %b want 0001", s_meta_ready); end
    $display("test_fifo_full done");
  endtask

  task automatic test_push_pop_same_cycle();
    match_valid = 1'b1; match_last = 1'b1;
    #1;
    checks++; if (out_match_valid !== 4'b0010) begin errors++; $display("FAIL pp_head1: got %b want 0010", out_match_valid); end
    @(negedge clk);
    match_valid = 1'b0; match_last = 1'b0; s_meta_valid[0] = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 4'b0001) begin errors++; $display("FAIL pp_port0_data: got %b want 0001", s_axis_tready); end
    @(negedge clk);
    drive_port(0, 0, 0, 0, 0, 0);
    drive_port(1, 1, 1, 1, 1, 0);
    match_valid = 1'b1; match_last = 1'b1;
    #1;
    checks++; if (out_match_valid !== 4'b0100) begin errors++; $display("FAIL pp_head2: got %b want 0100", out_match_valid); end
    @(negedge clk);
    match_last = 1'b0;
    #1;
    checks++; if (out_match_valid !== 4'b1000) begin errors++; $display("FAIL pp_next_head: got %b want 1000", out_match_valid); end
    checks++; if (s_meta_ready !== 4'b0010) begin errors++; $display("FAIL pp_grant1: got %b want 0010", s_meta_ready); end
    @(negedge clk);
    match_valid = 1'b0; s_meta_valid[1] = 1'b0;
    #1;
    checks++; if (m_axis_tdata !== beat_data(1, 0)) begin errors++; $display("FAIL pp_port1_tdata: got %h want %h", m_axis_tdata, beat_data(1, 0)); end
    @(negedge clk);
    drive_port(1, 0, 0, 0, 0, 0);
    state_valid_in = 1'b1;
    #1;
    checks++; if (out_state_valid !== 4'b0010) begin errors++; $display("FAIL pp_last_owner: got %b want 0010", out_state_valid); end
    state_valid_in = 1'b0;
    $display("test_push_pop_same_cycle done");
  endtask

  task automatic test_tag_err();
    int exp_head [7] = '{3, 0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      match_valid = 1'b1; match_last = 1'b1; out_match_release = 4'b1111;
      #1;
      checks++; if (out_match_valid !== 4'(1 << exp_head[i])) begin errors++; $display("FAIL drain_head%0d: got %b want %b", i, out_match_valid, 4'(1 << exp_head[i])); end
    end
    @(negedge clk);
    out_match_release = 4'b0000;
    #1;
    checks++; if (out_match_valid !== 4'b0000) begin errors++; $display("FAIL empty_match_valid: got %b want 0000", out_match_valid); end
    checks++; if (match_release !== 1'b1) begin errors++; $display("FAIL empty_release: got %b want 1", match_release); end
    @(negedge clk);
    match_valid = 1'b0; match_last = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tag_err_set: got %b want 1", tag_err); end
    @(negedge clk); #1;
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tag_err_sticky: got %b want 1", tag_err); end
    $display("test_tag_err done");
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    drive_port(1, 1, 1, 0, 1, 0);
    @(negedge clk); #1;
    checks++; if (s_meta_ready !== 4'b0010) begin errors++; $display("FAIL mid_meta: got %b want 0010", s_meta_ready); end
    @(negedge clk);
    s_meta_valid[1] = 1'b0;
    @(negedge clk);
    drive_port(1, 1, 0, 0, 0, 1);
    #1;
    checks++; if (s_axis_tready !== 4'b0010) begin errors++; $display("FAIL mid_beat2_ready: got %b want 0010", s_axis_tready); end
    rst_n = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL mid_rst_tready: got %b want 0000", s_axis_tready); end
    checks++; if ({m_axis_tvalid, m_meta_valid} !== 2'b00) begin errors++; $display("FAIL mid_rst_valid: got %b want 00", {m_axis_tvalid, m_meta_valid}); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL mid_rst_tag_err: got %b want 0", tag_err); end
    @(negedge clk);
    drive_port(1, 1, 0, 1, 1, 2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if ({m_axis_tvalid, m_meta_valid} !== 2'b00) begin errors++; $display("FAIL mid_no_tfirst_grant: got %b want 00", {m_axis_tvalid, m_meta_valid}); end
    end
    drive_port(1, 1, 1, 1, 1, 0);
    @(negedge clk); #1;
    checks++; if (s_meta_ready !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", s_meta_ready); end
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_priority();
    test_match_routing();
    test_round_robin();
    test_fifo_full();
    test_push_pop_same_cycle();
    test_tag_err();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
